// File: rtl/gelato_pkg.sv
// Shared types and widths for the gelato instruction fetch unit.
// The FSM state type, the latched fetch entry and the alignment helper live here.
package gelato_pkg;

  localparam int ADDR_W       = 32;
  localparam int WARP_NUM_W   = 5;
  localparam int THREAD_NUM_W = 32;
  localparam int INST_WIDTH   = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } ifetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]       pc;
    logic [WARP_NUM_W-1:0]   warp_num;
    logic [THREAD_NUM_W-1:0] thread_mask;
  } fetch_entry_t;

  // Only the two low pc bits decide word alignment.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/gelato_ifetch_unit_if.sv
// Bundle of the three links around the fetch unit: PC table in, instruction memory, decode out.
// Every *_valid/*_ready pair: a transfer happens on a rising clk edge where both are high; the
// sender holds valid and its payload steady until that edge; ready may depend on valid.
interface gelato_ifetch_unit_if #(
  parameter int ADDR_WIDTH     = gelato_pkg::ADDR_W,
  parameter int WARP_NUM_WIDTH = gelato_pkg::WARP_NUM_W,
  parameter int THREAD_NUM     = gelato_pkg::THREAD_NUM_W,
  parameter int INST_WIDTH     = gelato_pkg::INST_WIDTH
) ();

  logic                      pc_valid;
  logic                      pc_ready;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [WARP_NUM_WIDTH-1:0] warp_num;
  logic [THREAD_NUM-1:0]     thread_mask;
  logic                      flush;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [ADDR_WIDTH-1:0]     mem_req_addr;
  logic                      mem_rsp_valid;
  logic [INST_WIDTH-1:0]     mem_rsp_data;

  logic                      dec_valid;
  logic                      dec_ready;
  logic [INST_WIDTH-1:0]     dec_inst;
  logic [ADDR_WIDTH-1:0]     dec_pc;
  logic [WARP_NUM_WIDTH-1:0] dec_warp_num;
  logic [THREAD_NUM-1:0]     dec_thread_mask;
  logic                      dec_misalign;

  // The fetch unit itself.
  modport slave (
    input  pc_valid, pc, warp_num, thread_mask, flush,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  dec_ready,
    output pc_ready, mem_req_valid, mem_req_addr,
    output dec_valid, dec_inst, dec_pc, dec_warp_num, dec_thread_mask, dec_misalign
  );

  // The surrounding pipeline: PC table, instruction memory and decoder.
  modport master (
    output pc_valid, pc, warp_num, thread_mask, flush,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output dec_ready,
    input  pc_ready, mem_req_valid, mem_req_addr,
    input  dec_valid, dec_inst, dec_pc, dec_warp_num, dec_thread_mask, dec_misalign
  );

endinterface

// File: rtl/gelato_ifetch_unit.sv
// Instruction fetch unit: one fetch in flight, IDLE -> REQ -> WAIT -> OUT, with DRAIN for killed fetches.
// Define GELATO_IFETCH_ALIGN_CHECK_EN to short-circuit misaligned pcs to decode with dec_misalign set.
module gelato_ifetch_unit #(
  parameter int ADDR_WIDTH     = gelato_pkg::ADDR_W,
  parameter int WARP_NUM_WIDTH = gelato_pkg::WARP_NUM_W,
  parameter int THREAD_NUM     = gelato_pkg::THREAD_NUM_W,
  parameter int INST_WIDTH     = gelato_pkg::INST_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gelato_ifetch_unit_if.slave      bus,
  output gelato_pkg::ifetch_state_e state_dbg
);
  import gelato_pkg::*;

  ifetch_state_e         state;
  fetch_entry_t          entry;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  pc_ready_q;
  logic                  mem_req_valid_q;
  logic                  dec_valid_q;
  logic                  accept;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
  logic                  misalign_q;
`endif

  assign accept = (state == IDLE) && pc_ready_q && bus.pc_valid && !bus.flush;

  // pc_ready is registered so it stays low through reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      entry           <= '0;
      inst_q          <= '0;
      pc_ready_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      dec_valid_q     <= 1'b0;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
      misalign_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          pc_ready_q <= 1'b1;
          if (accept) begin
            entry      <= '{pc:          ADDR_W'(bus.pc),
                            warp_num:    WARP_NUM_W'(bus.warp_num),
                            thread_mask: THREAD_NUM_W'(bus.thread_mask)};
            pc_ready_q <= 1'b0;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
            if (pc_misaligned(bus.pc[1:0])) begin
              inst_q      <= '0;
              misalign_q  <= 1'b1;
              dec_valid_q <= 1'b1;
              state       <= OUT;
            end else begin
              misalign_q      <= 1'b0;
              mem_req_valid_q <= 1'b1;
              state           <= REQ;
            end
`else
            mem_req_valid_q <= 1'b1;
            state           <= REQ;
`endif
          end
        end
        REQ: begin
          // A request accepted in the same cycle as a flush still owes a response.
          if (bus.flush) begin
            mem_req_valid_q <= 1'b0;
            if (bus.mem_req_ready) begin
              state <= DRAIN;
            end else begin
              pc_ready_q <= 1'b1;
              state      <= IDLE;
            end
          end else if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (bus.flush) begin
              pc_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              inst_q      <= INST_WIDTH'(bus.mem_rsp_data);
              dec_valid_q <= 1'b1;
              state       <= OUT;
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        OUT: begin
          if (bus.flush || bus.dec_ready) begin
            dec_valid_q <= 1'b0;
            pc_ready_q  <= 1'b1;
            state       <= IDLE;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
          end
        end
        DRAIN: begin
          if (bus.mem_rsp_valid) begin
            pc_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc_ready        = pc_ready_q;
  assign bus.mem_req_valid   = mem_req_valid_q;
  assign bus.mem_req_addr    = ADDR_WIDTH'(entry.pc);
  assign bus.dec_valid       = dec_valid_q;
  assign bus.dec_inst        = inst_q;
  assign bus.dec_pc          = ADDR_WIDTH'(entry.pc);
  assign bus.dec_warp_num    = WARP_NUM_WIDTH'(entry.warp_num);
  assign bus.dec_thread_mask = THREAD_NUM'(entry.thread_mask);
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
  assign bus.dec_misalign    = misalign_q;
`else
  assign bus.dec_misalign    = 1'b0;
`endif
  assign state_dbg           = state;

  // Memory may only answer while a response is owed.
  rsp_only_when_owed: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_rsp_valid |-> (state == WAIT || state == DRAIN));

endmodule

// File: tb/tb_gelato_ifetch_unit.sv
// Directed plus randomized bench for gelato_ifetch_unit with a memory model and an expected-output queue.
// Expected decode words are {misalign, inst, pc, warp_num, thread_mask}.
module tb_gelato_ifetch_unit;
  import gelato_pkg::*;

  localparam int EW = 1 + 32 + 32 + 5 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gelato_ifetch_unit_if bus ();
  ifetch_state_e state_dbg;

  gelato_ifetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  bit          owed = 1'b0;
  int          owed_wait = 0;
  logic [31:0] owed_addr = '0;
  int          mem_stall = 0;
  int          mem_ready_pct = 100;
  int          rsp_delay_min = 1;
  int          rsp_delay_max = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;
  int          mem_acc_cnt = 0;

  bit          prev_hold = 1'b0;
  logic [EW-1:0] prev_dec = '0;
  bit          prev_req_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [EW-1:0] expect_of(input logic [31:0] p, input logic [4:0] w,
                                              input logic [31:0] m);
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    if (p[1:0] != 2'b00) return {1'b1, 32'h0, p, w, m};
`endif
    return {1'b0, (ovr_en ? ovr_data : mem_word(p)), p, w, m};
  endfunction

  function automatic logic [EW-1:0] dec_word();
    return {bus.dec_misalign, bus.dec_inst, bus.dec_pc, bus.dec_warp_num, bus.dec_thread_mask};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_drive();
    if (owed) begin
      if (owed_wait == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = ovr_en ? ovr_data : mem_word(owed_addr);
        owed = 1'b0;
      end else begin
        owed_wait--;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
      end
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = $urandom;
    end
    if (mem_stall > 0) begin
      bus.mem_req_ready = 1'b0;
      mem_stall--;
    end else begin
      bus.mem_req_ready = ($urandom_range(99, 0) < mem_ready_pct);
    end
  endtask

  // Evaluated with all inputs settled, just before the edge that performs the transfers.
  task automatic record();
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      mem_acc_cnt++;
      owed      = 1'b1;
      owed_wait = $urandom_range(rsp_delay_max, rsp_delay_min) - 1;
      owed_addr = bus.mem_req_addr;
      if (exp_q.size() > 0) chk("mem_addr", bus.mem_req_addr, exp_q[0][68:37]);
      else chk("mem_req_no_fetch", 1'b1, 1'b0);
    end
    if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
      if (exp_q.size() == 0) chk("dec_spurious", 1'b1, 1'b0);
      else chk("dec_out", dec_word(), exp_q.pop_front());
    end
    if (bus.flush) exp_q.delete();
    if (bus.pc_valid && bus.pc_ready && !bus.flush)
      exp_q.push_back(expect_of(bus.pc, bus.warp_num, bus.thread_mask));
    prev_hold     = bus.dec_valid && !bus.dec_ready && !bus.flush;
    prev_dec      = dec_word();
    prev_req_hold = bus.mem_req_valid && !bus.mem_req_ready && !bus.flush;
    prev_addr     = bus.mem_req_addr;
  endtask

  task automatic tick();
    mem_drive();
    record();
    @(posedge clk);
    @(negedge clk);
    if (prev_hold) chk("dec_hold", {bus.dec_valid, dec_word()}, {1'b1, prev_dec});
    if (prev_req_hold) chk("req_hold", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, prev_addr});
    if (bus.pc_ready) chk("one_in_flight", {owed, 32'(exp_q.size())}, '0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || owed || !bus.pc_ready) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, (n < 50), 1'b1);
  endtask

  task automatic present(input logic [31:0] p, input logic [4:0] w, input logic [31:0] m);
    bus.pc = p;
    bus.warp_num = w;
    bus.thread_mask = m;
    bus.pc_valid = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    int acc0;
    bus.pc_valid = 1'b0; bus.pc = '0; bus.warp_num = '0; bus.thread_mask = '0; bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.dec_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_pc_ready", bus.pc_ready, 1'b0);
    chk("rst_valids", {bus.mem_req_valid, bus.dec_valid, bus.dec_misalign}, 3'b000);
    chk("rst_data", {bus.mem_req_addr, dec_word()}, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_pc_ready", bus.pc_ready, 1'b1);

    // basic fetch, zero-wait memory
    ovr_en = 1'b1; ovr_data = 32'h0000_0013;
    present(32'h100, 5'd3, 32'hFFFF_FFFF);
    tick();
    bus.pc_valid = 1'b0; bus.pc = $urandom;
    chk("accept_drops_ready", bus.pc_ready, 1'b0);
    lat = 1;
    while (!bus.dec_valid && lat < 20) begin tick(); lat++; end
    chk("latency", lat, 3);
    chk("basic_dec", dec_word(), {1'b0, 32'h0000_0013, 32'h100, 5'd3, 32'hFFFF_FFFF});
    tick();
    ovr_en = 1'b0;
    wait_idle("basic_idle");

    // memory back-pressure
    acc0 = mem_acc_cnt;
    mem_stall = 6;
    present(32'h100, 5'd9, 32'h0000_FFFF);
    tick();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {bus.mem_req_valid, bus.mem_req_addr, bus.pc_ready}, {1'b1, 32'h100, 1'b0});
    end
    wait_idle("stall_idle");
    chk("single_req", mem_acc_cnt - acc0, 1);

    // decode back-pressure
    bus.dec_ready = 1'b0;
    present(32'h300, 5'd7, 32'h0F0F_0F0F);
    tick();
    bus.pc = 32'h400;
    lat = 0;
    while (!bus.dec_valid && lat < 20) begin tick(); lat++; end
    chk("dec_wait_bound", (lat < 20), 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dec_stall", {bus.dec_valid, bus.dec_pc, bus.pc_ready}, {1'b1, 32'h300, 1'b0});
    end
    bus.pc_valid = 1'b0;
    bus.dec_ready = 1'b1;
    tick();
    chk("dec_release_ready", bus.pc_ready, 1'b1);
    wait_idle("dec_idle");

    // flush while waiting for memory
    rsp_delay_min = 3; rsp_delay_max = 3;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    present(32'h500, 5'd2, 32'h1);
    tick();
    bus.pc_valid = 1'b0;
    tick();
    chk("flush_in_wait", state_dbg, WAIT);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_dec", bus.dec_valid, 1'b0);
      tick();
    end
    chk("flush_pc_ready", {bus.pc_ready, owed}, 2'b10);
    ovr_en = 1'b0;

    // async reset mid-WAIT
    present(32'h600, 5'd4, 32'hAAAA_5555);
    tick();
    bus.pc_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", {bus.pc_ready, bus.mem_req_valid, bus.dec_valid, bus.mem_req_addr, dec_word()}, '0);
    owed = 1'b0; exp_q.delete(); prev_hold = 1'b0; prev_req_hold = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_release", {bus.pc_ready, state_dbg}, {1'b1, IDLE});
    rsp_delay_min = 1; rsp_delay_max = 1;

    // misaligned pc
    present(32'h102, 5'd1, 32'h1);
    tick();
    bus.pc_valid = 1'b0;
`ifdef GELATO_IFETCH_ALIGN_CHECK_EN
    chk("misalign_out", {bus.mem_req_valid, bus.dec_valid, bus.dec_misalign, bus.dec_inst},
        {1'b0, 1'b1, 1'b1, 32'h0});
`else
    chk("misalign_req", {bus.mem_req_valid, bus.mem_req_addr, bus.dec_misalign}, {1'b1, 32'h102, 1'b0});
`endif
    wait_idle("misalign_idle");

    // randomized traffic
    mem_ready_pct = 60; rsp_delay_min = 1; rsp_delay_max = 3;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(3, 0) != 0) p[1:0] = 2'b00;
      bus.pc_valid    = ($urandom_range(99, 0) < 60);
      bus.pc          = p;
      bus.warp_num    = 5'($urandom);
      bus.thread_mask = $urandom;
      bus.flush       = ($urandom_range(99, 0) < 5);
      bus.dec_ready   = ($urandom_range(99, 0) < 70);
      tick();
    end
    bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.dec_ready = 1'b1; mem_ready_pct = 100;
    wait_idle("random_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
